avfs_controller: RTL and testbench
==================================

Name: avfs_controller

Overview:
Adaptive voltage/frequency scaling controller. It counts cycles with `activity` high over a programmable window. At the end of each window it steps the 4-bit performance level `freq_sel` up or down against programmable thresholds. A simple single-cycle APB-style register port configures the block and exposes status. `freq_sel` drives the downstream clock/voltage selector.

Parameters:
- RST_LEVEL, 4'h8: `freq_sel` value after reset.
- CNT_W, 16: width of the window and activity counters, and of the threshold fields.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- activity, input, 1: per-cycle busy indication, sampled every clk.
- freq_sel, output, 4: current performance level; 0 is slowest, 15 is fastest. Registered.
- apb_sel, input, 1: register access select.
- apb_we, input, 1: 1 = write, 0 = read.
- apb_addr, input, 8: byte address.
- apb_wdata, input, 32: write data.
- apb_rdata, output, 32: read data.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low (`rst_n`); all state clears on assertion.
  - Reset values:
    - freq_sel = RST_LEVEL.
    - CTRL = 0x1 (enable=1, manual=0, man_lvl=0).
    - WINDOW = 64, UP_TH = 48, DN_TH = 16.
    - LIMITS min = 0, max = 15.
    - Window counter = 0, activity counter = 0, last count = 0.
    - apb_rdata = 0.
- Register map (exact 8-bit address match):
  - 0x00 CTRL (RW): [0] enable, [1] manual, [7:4] man_lvl. Other bits read 0.
  - 0x04 WINDOW (RW): [15:0]. A value of 0 is treated as 1.
  - 0x08 UP_TH (RW): [15:0].
  - 0x0C DN_TH (RW): [15:0].
  - 0x10 LIMITS (RW): [3:0] min, [11:8] max.
  - 0x14 STATUS (RO): [3:0] freq_sel, [31:16] last completed window activity count.
  - 0x18 ACT_CNT (RO): [15:0] in-progress activity count.
- APB write: takes effect at the rising clk edge where apb_sel=1 and apb_we=1. There are no wait states. Writes to RO or unmapped addresses are ignored.
- APB read:
  - apb_rdata is combinational: register contents when apb_sel=1 and apb_we=0.
  - apb_rdata is 0 otherwise, and 0 for unmapped addresses (e.g. 0xFF).
- Effective limits: lo = min(min, max), hi = max. Apply clamp(x) = x limited to [lo, hi].
- Auto mode (enable=1, manual=0):
  - Window counter wc increments each cycle. The activity counter increments on each cycle with activity=1 and saturates at all-ones.
  - When wc == WINDOW-1, form the total including the current cycle's activity, then:
    - If total >= UP_TH and freq_sel < hi: freq_sel += 1.
    - Else if total <= DN_TH and freq_sel > lo: freq_sel -= 1.
    - Otherwise freq_sel holds.
    - UP has priority when both conditions are true.
  - At the same window-end edge: last count = total; wc and the activity counter restart at 0.
  - freq_sel changes by at most 1 per window. New values are visible the cycle after the window-end edge.
- Manual mode (enable=1, manual=1): freq_sel = clamp(man_lvl) on every edge. Counters are held at 0.
- Disabled (enable=0): counters are held at 0 and freq_sel holds its value.
- Limit writes: if freq_sel falls outside [lo, hi] in any mode, it is clamped on the next edge. Clamping takes priority over step.
- Writing CTRL, WINDOW or a threshold restarts the current window: counters go to 0 on that edge.
- Reset mid-window: counters are discarded and freq_sel returns to RST_LEVEL immediately (asynchronous).
- freq_sel never wraps; it saturates at hi/lo.

Test Plan:
1. Reset check: assert rst_n=0 for 2 cycles. Required: freq_sel=8; reads give CTRL=0x1, WINDOW=64, UP_TH=48, DN_TH=16, LIMITS=0xF00; read of 0xFF = 0.
2. Rising level: WINDOW=8, UP_TH=6, activity=1 constantly. Required: freq_sel goes 8→9→…→15, one step every 8 cycles, then holds at 15; STATUS[31:16]=8.
3. Falling level: activity=0 with DN_TH=16, WINDOW=64. Required: freq_sel decrements once per 64 cycles down to 0, never wraps.
4. Manual mode: write 0xFFFFFFFF to 0x00. Required: freq_sel=F next cycle. Then write LIMITS=0x0A03. Required: freq_sel=A next cycle. Then write CTRL=0x0 (disabled). Required: freq_sel holds A under any activity.
5. APB idle and unmapped: with apb_sel=0, apb_rdata=0 and no register changes. Write 0x1234 to 0xFF; all registers are unchanged.
6. Reset mid-window: with activity counting in progress, pulse rst_n low for 1 cycle. Required: freq_sel=8 immediately and ACT_CNT=0.

Source files
------------

// File: rtl/avfs_controller.sv
// Adaptive voltage/frequency scaling controller: windowed activity count steps freq_sel up/down.
// Latency: freq_sel updates on the edge after a window end; APB writes land on the access edge, reads are combinational.
// Backpressure: none; APB port has no wait states and activity is sampled every cycle.
//
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   activity              - per-cycle busy indication
//   freq_sel[3:0]         - registered performance level (0 slowest, 15 fastest)
//   apb_sel/apb_we        - single-cycle register access select / write enable
//   apb_addr/apb_wdata    - byte address / write data
//   apb_rdata             - combinational read data (0 when idle or unmapped)
module avfs_controller #(
    parameter logic [3:0] RST_LEVEL = 4'h8,
    parameter int         CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        activity,
    output logic [3:0]  freq_sel,
    input  logic        apb_sel,
    input  logic        apb_we,
    input  logic [7:0]  apb_addr,
    input  logic [31:0] apb_wdata,
    output logic [31:0] apb_rdata
);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_WINDOW = 8'h04;
    localparam logic [7:0] ADDR_UP_TH  = 8'h08;
    localparam logic [7:0] ADDR_DN_TH  = 8'h0C;
    localparam logic [7:0] ADDR_LIMITS = 8'h10;
    localparam logic [7:0] ADDR_STATUS = 8'h14;
    localparam logic [7:0] ADDR_ACT    = 8'h18;

    logic             enable_q,  enable_d;
    logic             manual_q,  manual_d;
    logic [3:0]       man_lvl_q, man_lvl_d;
    logic [CNT_W-1:0] window_q,  window_d;
    logic [CNT_W-1:0] up_th_q,   up_th_d;
    logic [CNT_W-1:0] dn_th_q,   dn_th_d;
    logic [3:0]       lim_min_q, lim_min_d;
    logic [3:0]       lim_max_q, lim_max_d;
    logic [3:0]       freq_q,    freq_d;
    logic [CNT_W-1:0] wc_q,      wc_d;
    logic [CNT_W-1:0] act_q,     act_d;
    logic [CNT_W-1:0] last_q,    last_d;

    logic [3:0]       lo, hi;
    logic [CNT_W-1:0] win_last;
    logic [CNT_W-1:0] act_total;
    logic             auto_mode, win_end, wr_en, restart;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^apb_wdata[31:16];

    function automatic logic [3:0] clamp(input logic [3:0] x, input logic [3:0] l,
                                         input logic [3:0] h);
        if (x < l)      return l;
        else if (x > h) return h;
        else            return x;
    endfunction

    always_comb begin
        // An inverted min/max pair collapses the low bound onto max.
        lo        = (lim_min_q < lim_max_q) ? lim_min_q : lim_max_q;
        hi        = lim_max_q;
        // WINDOW of 0 behaves as 1, i.e. every cycle ends a window.
        win_last  = (window_q == '0) ? '0 : window_q - 1'b1;
        act_total = (act_q == '1) ? act_q : act_q + CNT_W'(activity);
        auto_mode = enable_q & ~manual_q;
        win_end   = auto_mode && (wc_q == win_last);
        wr_en     = apb_sel & apb_we;
        restart   = wr_en && (apb_addr == ADDR_CTRL || apb_addr == ADDR_WINDOW ||
                              apb_addr == ADDR_UP_TH || apb_addr == ADDR_DN_TH);

        enable_d  = enable_q;
        manual_d  = manual_q;
        man_lvl_d = man_lvl_q;
        window_d  = window_q;
        up_th_d   = up_th_q;
        dn_th_d   = dn_th_q;
        lim_min_d = lim_min_q;
        lim_max_d = lim_max_q;
        freq_d    = freq_q;
        wc_d      = wc_q;
        act_d     = act_q;
        last_d    = last_q;

        // Level update: manual override, then out-of-range clamp, then windowed step.
        if (enable_q && manual_q) begin
            freq_d = clamp(man_lvl_q, lo, hi);
        end else if (freq_q < lo || freq_q > hi) begin
            freq_d = clamp(freq_q, lo, hi);
        end else if (win_end) begin
            if (act_total >= up_th_q && freq_q < hi)      freq_d = freq_q + 4'd1;
            else if (act_total <= dn_th_q && freq_q > lo) freq_d = freq_q - 4'd1;
        end

        // Window and activity counters only run in auto mode.
        if (!auto_mode) begin
            wc_d  = '0;
            act_d = '0;
        end else if (win_end) begin
            wc_d   = '0;
            act_d  = '0;
            last_d = act_total;
        end else begin
            wc_d  = wc_q + 1'b1;
            act_d = act_total;
        end

        // Reprogramming control or thresholds starts a fresh window.
        if (restart) begin
            wc_d  = '0;
            act_d = '0;
        end

        if (wr_en) begin
            case (apb_addr)
                ADDR_CTRL: begin
                    enable_d  = apb_wdata[0];
                    manual_d  = apb_wdata[1];
                    man_lvl_d = apb_wdata[7:4];
                end
                ADDR_WINDOW: window_d = apb_wdata[CNT_W-1:0];
                ADDR_UP_TH:  up_th_d  = apb_wdata[CNT_W-1:0];
                ADDR_DN_TH:  dn_th_d  = apb_wdata[CNT_W-1:0];
                ADDR_LIMITS: begin
                    lim_min_d = apb_wdata[3:0];
                    lim_max_d = apb_wdata[11:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= 1'b1;
            manual_q  <= 1'b0;
            man_lvl_q <= 4'd0;
            window_q  <= CNT_W'(64);
            up_th_q   <= CNT_W'(48);
            dn_th_q   <= CNT_W'(16);
            lim_min_q <= 4'd0;
            lim_max_q <= 4'd15;
            freq_q    <= RST_LEVEL;
            wc_q      <= '0;
            act_q     <= '0;
            last_q    <= '0;
        end else begin
            enable_q  <= enable_d;
            manual_q  <= manual_d;
            man_lvl_q <= man_lvl_d;
            window_q  <= window_d;
            up_th_q   <= up_th_d;
            dn_th_q   <= dn_th_d;
            lim_min_q <= lim_min_d;
            lim_max_q <= lim_max_d;
            freq_q    <= freq_d;
            wc_q      <= wc_d;
            act_q     <= act_d;
            last_q    <= last_d;
        end
    end

    assign freq_sel = freq_q;

    always_comb begin
        apb_rdata = '0;
        if (apb_sel && !apb_we) begin
            case (apb_addr)
                ADDR_CTRL: begin
                    apb_rdata[0]   = enable_q;
                    apb_rdata[1]   = manual_q;
                    apb_rdata[7:4] = man_lvl_q;
                end
                ADDR_WINDOW: apb_rdata = 32'(window_q);
                ADDR_UP_TH:  apb_rdata = 32'(up_th_q);
                ADDR_DN_TH:  apb_rdata = 32'(dn_th_q);
                ADDR_LIMITS: begin
                    apb_rdata[3:0]  = lim_min_q;
                    apb_rdata[11:8] = lim_max_q;
                end
                ADDR_STATUS: begin
                    apb_rdata[3:0]   = freq_q;
                    apb_rdata[31:16] = 16'(last_q);
                end
                ADDR_ACT: apb_rdata = 32'(act_q);
                default:  apb_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_avfs_controller.sv
// Testbench for avfs_controller: directed scenarios plus a randomized run against a reference model.
// Latency: one model step per DUT clock edge; outputs sampled 1 ns after the rising edge.
// Backpressure: none; the bench drives activity and APB accesses freely.
module tb_avfs_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        activity = 1'b0;
    logic [3:0]  freq_sel;
    logic        apb_sel = 1'b0;
    logic        apb_we = 1'b0;
    logic [7:0]  apb_addr = 8'h00;
    logic [31:0] apb_wdata = 32'h0;
    logic [31:0] apb_rdata;

    int vecs = 0;
    int errs = 0;

    // Reference model state, plain integers.
    int m_en, m_man, m_lvl, m_win, m_up, m_dn, m_min, m_max;
    int m_fs, m_wc, m_act, m_last;

    avfs_controller #(.RST_LEVEL(4'h8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .activity  (activity),
        .freq_sel  (freq_sel),
        .apb_sel   (apb_sel),
        .apb_we    (apb_we),
        .apb_addr  (apb_addr),
        .apb_wdata (apb_wdata),
        .apb_rdata (apb_rdata)
    );

    always #5 clk = ~clk;

    function automatic int clampi(int x, int lo, int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_reset();
        m_en = 1; m_man = 0; m_lvl = 0; m_win = 64; m_up = 48; m_dn = 16;
        m_min = 0; m_max = 15; m_fs = 8; m_wc = 0; m_act = 0; m_last = 0;
    endtask

    // One clock edge of the documented behaviour, using pre-edge state throughout.
    task automatic model_edge(input int act, input bit wr, input logic [7:0] a, input logic [31:0] d);
        int lo, hi, win, total, nfs, nwc, nact, nlast;
        bit is_auto, at_end;
        lo = (m_min < m_max) ? m_min : m_max;
        hi = m_max;
        win = (m_win == 0) ? 1 : m_win;
        total = m_act + act;
        if (total > 65535) total = 65535;
        is_auto = (m_en == 1) && (m_man == 0);
        at_end = is_auto && (m_wc == win - 1);
        nfs = m_fs; nwc = m_wc + 1; nact = total; nlast = m_last;
        if (m_en == 1 && m_man == 1)  nfs = clampi(m_lvl, lo, hi);
        else if (m_fs < lo || m_fs > hi) nfs = clampi(m_fs, lo, hi);
        else if (at_end) begin
            if (total >= m_up && m_fs < hi)      nfs = m_fs + 1;
            else if (total <= m_dn && m_fs > lo) nfs = m_fs - 1;
        end
        if (!is_auto) begin nwc = 0; nact = 0; end
        else if (at_end) begin nwc = 0; nact = 0; nlast = total; end
        if (wr && (a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C)) begin
            nwc = 0; nact = 0;
        end
        if (wr) begin
            case (a)
                8'h00: begin m_en = int'(d[0]); m_man = int'(d[1]); m_lvl = int'(d[7:4]); end
                8'h04: m_win = int'(d[15:0]);
                8'h08: m_up  = int'(d[15:0]);
                8'h0C: m_dn  = int'(d[15:0]);
                8'h10: begin m_min = int'(d[3:0]); m_max = int'(d[11:8]); end
                default: ;
            endcase
        end
        m_fs = nfs; m_wc = nwc; m_act = nact; m_last = nlast;
    endtask

    // Drive one cycle of inputs, advance model across the edge, sample 1 ns later.
    task automatic tick(input bit act, input bit sel, input bit we, input logic [7:0] a,
                        input logic [31:0] d);
        activity = act; apb_sel = sel; apb_we = we; apb_addr = a; apb_wdata = d;
        @(posedge clk);
        model_edge(int'(act), sel && we, a, d);
        #1;
        apb_sel = 1'b0; apb_we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        tick(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] v);
        apb_sel = 1'b1; apb_we = 1'b0; apb_addr = a;
        #1;
        v = apb_rdata;
        apb_sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_v [7] = '{32'h1, 32'd64, 32'd48, 32'd16, 32'hF00, 32'h8, 32'h0};
        logic [7:0]  adr   [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'hFF};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        vecs++;
        if (freq_sel !== 4'h8) begin
            errs++; $display("FAIL reset_freq_sel got=%0h exp=8", freq_sel);
        end
        for (int i = 0; i < 7; i++) begin
            apb_rd(adr[i], v);
            vecs++;
            if (v !== exp_v[i]) begin
                errs++; $display("FAIL reset_read addr=%0h got=%0h exp=%0h", adr[i], v, exp_v[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(0, 1'b0, 8'h00, 32'h0);
        #1;
    endtask

    task automatic test_rising();
        logic [31:0] v;
        wr(8'h04, 32'd8);
        wr(8'h08, 32'd6);
        wr(8'h0C, 32'd2);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 8; c++) begin
                tick(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
                vecs++;
                if (freq_sel !== 4'(m_fs)) begin
                    errs++; $display("FAIL rising_model got=%0d exp=%0d", freq_sel, m_fs);
                end
            end
            vecs++;
            if (int'(freq_sel) != ((8 + k + 1 > 15) ? 15 : 8 + k + 1)) begin
                errs++; $display("FAIL rising_step win=%0d got=%0d", k, freq_sel);
            end
        end
        apb_rd(8'h14, v);
        vecs++;
        if (v[31:16] !== 16'd8) begin
            errs++; $display("FAIL rising_status_last got=%0d exp=8", v[31:16]);
        end
    endtask

    task automatic test_falling();
        wr(8'h04, 32'd64);
        wr(8'h08, 32'd48);
        wr(8'h0C, 32'd16);
        for (int k = 0; k < 17; k++) begin
            for (int c = 0; c < 64; c++) tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            vecs++;
            if (int'(freq_sel) != ((14 - k < 0) ? 0 : 14 - k) || freq_sel !== 4'(m_fs)) begin
                errs++; $display("FAIL falling_step win=%0d got=%0d model=%0d", k, freq_sel, m_fs);
            end
        end
    endtask

    task automatic test_manual();
        logic [31:0] v;
        wr(8'h00, 32'hFFFF_FFFF);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        vecs++;
        if (freq_sel !== 4'hF) begin
            errs++; $display("FAIL manual_level got=%0h exp=f", freq_sel);
        end
        wr(8'h10, 32'h0000_0A03);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        vecs++;
        if (freq_sel !== 4'hA) begin
            errs++; $display("FAIL manual_limit_clamp got=%0h exp=a", freq_sel);
        end
        wr(8'h00, 32'h0);
        for (int c = 0; c < 30; c++) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 32'h0);
            apb_rd(8'h18, v);
            vecs++;
            if (freq_sel !== 4'hA || v !== 32'h0) begin
                errs++; $display("FAIL disabled_hold got=%0h act=%0d exp=a,0", freq_sel, v);
            end
        end
    endtask

    task automatic test_apb_idle();
        logic [31:0] v;
        logic [31:0] exp_v [6] = '{32'h0, 32'd64, 32'd48, 32'd16, 32'h0A03, 32'h0};
        logic [7:0]  adr   [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'hFF};
        apb_sel = 1'b0; apb_we = 1'b0; apb_addr = 8'h04;
        #1;
        vecs++;
        if (apb_rdata !== 32'h0) begin
            errs++; $display("FAIL idle_rdata got=%0h exp=0", apb_rdata);
        end
        wr(8'hFF, 32'h1234);
        tick(1'b0, 1'b0, 1'b1, 8'h04, 32'd5);
        wr(8'h14, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            apb_rd(adr[i], v);
            vecs++;
            if (v !== exp_v[i]) begin
                errs++; $display("FAIL unmapped_write addr=%0h got=%0h exp=%0h", adr[i], v, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        logic [31:0] v;
        wr(8'h10, 32'h0F00);
        wr(8'h00, 32'h1);
        for (int c = 0; c < 10; c++) tick(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        apb_rd(8'h18, v);
        vecs++;
        if (v !== 32'd10 || freq_sel !== 4'hA) begin
            errs++; $display("FAIL midwin_precount act=%0d fs=%0h exp=10,a", v, freq_sel);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (freq_sel !== 4'h8) begin
            errs++; $display("FAIL midwin_reset_fs got=%0h exp=8", freq_sel);
        end
        apb_rd(8'h18, v);
        vecs++;
        if (v !== 32'h0) begin
            errs++; $display("FAIL midwin_reset_act got=%0d exp=0", v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] v, d;
        logic [7:0]  a;
        logic [7:0]  addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'hFF};
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = addrs[$urandom_range(0, 7)];
                case (a)
                    8'h00: begin
                        d = $urandom & 32'hFF;
                        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                        if ($urandom_range(0, 2) != 0) d[1] = 1'b0;
                    end
                    8'h04, 8'h08, 8'h0C: d = 32'($urandom_range(0, 12));
                    8'h10: d = $urandom;
                    default: d = $urandom;
                endcase
                tick(1'($urandom_range(0, 1)), 1'b1, 1'b1, a, d);
            end else begin
                tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 32'h0);
            end
            vecs++;
            if (freq_sel !== 4'(m_fs)) begin
                errs++; $display("FAIL random_fs cyc=%0d got=%0d exp=%0d", n, freq_sel, m_fs);
            end
            apb_rd(8'h18, v);
            vecs++;
            if (v !== 32'(m_act)) begin
                errs++; $display("FAIL random_act cyc=%0d got=%0d exp=%0d", n, v, m_act);
            end
            apb_rd(8'h14, v);
            vecs++;
            if (v !== ((32'(m_last) << 16) | 32'(m_fs))) begin
                errs++; $display("FAIL random_status cyc=%0d got=%0h last=%0d fs=%0d", n, v, m_last, m_fs);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rising();
        test_falling();
        test_manual();
        test_apb_idle();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
